// File: rtl/rx_decode_pkg.sv
// rx_decode_pkg: shared state encoding and constants for the receive decode controller.
package rx_decode_pkg;
   localparam int BIT_CNT_W = 4;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
   typedef enum logic [2:0] {IDLE, SYNC, RCV, STORE, DONE, ERR, EOP_WAIT} state_e;
endpackage

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: counts non-stuffed bits 0..8, saturating at 8, with a synchronous clear.
module rx_bit_counter
   import rx_decode_pkg::*;
(
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 clear,
   input  logic                 count_enable,
   output logic [BIT_CNT_W-1:0] bit_cnt,
   output logic                 rollover
);
   logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
   // A bit arriving in the clear cycle still counts, so clear restarts at 1 then.
   always_comb begin
      cnt_d = clear ? '0 : cnt_q;
      if (count_enable && cnt_d != BIT_CNT_W'(8)) cnt_d = cnt_d + BIT_CNT_W'(1);
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
   assign bit_cnt  = cnt_q;
   assign rollover = cnt_q == BIT_CNT_W'(8);
endmodule

// File: rtl/rx_decode_ctrl.sv
// rx_decode_ctrl: receive sequencer validating sync, counting destuffed bits into bytes
// and strobing RX FIFO writes, with sticky stuffing/framing/overflow error reporting.
module rx_decode_ctrl
   import rx_decode_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         MAX_BYTES = 64
)(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       d_edge,
   input  logic       shift_enable,
   input  logic       d_orig,
   input  logic       stuff_bit,
   input  logic       eop,
   input  logic [7:0] rcv_data,
   input  logic       fifo_full,
   output logic       enable_timer,
   output logic       rcving,
   output logic       w_enable,
   output logic       r_error,
   output logic       packet_done,
   output logic [6:0] byte_count
);
   localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);
   state_e               state_q, state_d;
   logic [6:0]           byte_count_q, byte_count_d;
   logic                 r_error_q, r_error_d;
   logic                 w_enable_q, w_enable_d;
   logic                 eop_seen_q, eop_seen_d;
   logic                 valid_bit, cnt_clear, rollover;
   logic [BIT_CNT_W-1:0] bit_cnt;

   assign valid_bit = shift_enable & ~stuff_bit;

   rx_bit_counter u_bit_counter (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (cnt_clear),
      .count_enable (valid_bit),
      .bit_cnt      (bit_cnt),
      .rollover     (rollover)
   );

   // The write decision is made on the 8th bit and registered, so STORE just follows it.
   always_comb begin
      state_d      = state_q;
      byte_count_d = byte_count_q;
      r_error_d    = r_error_q;
      w_enable_d   = 1'b0;
      cnt_clear    = 1'b0;
      eop_seen_d   = (state_q != IDLE) && (eop_seen_q || eop);
      case (state_q)
         IDLE: begin
            cnt_clear = 1'b1;
            if (d_edge) begin
               r_error_d    = 1'b0;
               byte_count_d = '0;
               state_d      = SYNC;
            end
         end
         SYNC: begin
            if (rollover) begin
               cnt_clear = rcv_data == SYNC_BYTE;
               state_d   = cnt_clear ? RCV : ERR;
            end else if (eop) state_d = ERR;
         end
         RCV: begin
            if (eop) state_d = (bit_cnt == '0) ? DONE : ERR;
            else if (shift_enable && stuff_bit && d_orig) state_d = ERR;
            else if (valid_bit && bit_cnt == BIT_CNT_W'(7)) begin
               state_d    = STORE;
               w_enable_d = !fifo_full && byte_count_q != MAX_CNT;
            end
         end
         STORE: begin
            cnt_clear    = 1'b1;
            state_d      = w_enable_q ? RCV : ERR;
            byte_count_d = w_enable_q ? byte_count_q + 7'd1 : byte_count_q;
         end
         DONE: state_d = EOP_WAIT;
         ERR: begin
            r_error_d = 1'b1;
            state_d   = EOP_WAIT;
         end
         EOP_WAIT: if (eop_seen_q && !eop) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         byte_count_q <= '0;
         r_error_q    <= 1'b0;
         w_enable_q   <= 1'b0;
         eop_seen_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_count_q <= byte_count_d;
         r_error_q    <= r_error_d;
         w_enable_q   <= w_enable_d;
         eop_seen_q   <= eop_seen_d;
      end
   end

   assign enable_timer = state_q inside {SYNC, RCV, STORE};
   assign rcving       = state_q != IDLE;
   assign packet_done  = state_q == DONE;
   assign w_enable     = w_enable_q;
   assign r_error      = r_error_q;
   assign byte_count   = byte_count_q;
endmodule
